// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy master.
// State encoding and the full-word byte-enable value.
package wb_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator copying a block of 32-bit words,
// one read then one write per word, with an ack-wait timeout.
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int ADR_W   = 30,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             start_i,
  input  logic [ADR_W-1:0] src_i,
  input  logic [ADR_W-1:0] dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [3:0]       be_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  state_t           r_state;
  logic [ADR_W-1:0] r_src;
  logic [ADR_W-1:0] r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [CW-1:0]    r_wait;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_cyc;
  logic             r_we;
  logic [ADR_W-1:0] r_adr;
  logic [31:0]      r_dat;

  logic [LEN_W-1:0] w_idx_nx;
  logic             w_timeout;

  assign w_idx_nx  = r_idx + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (r_wait == TO_MAX);

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o  = r_err;
  assign cyc_o  = r_cyc;
  assign stb_o  = r_cyc;
  assign we_o   = r_we;
  assign be_o   = BE_FULL;
  assign adr_o  = r_adr;
  assign dat_o  = r_dat;

  // Copy sequencer: IDLE -> (RD -> WR)* -> FIN, registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            r_src  <= src_i;
            r_dst  <= dst_i;
            r_len  <= len_i;
            r_idx  <= '0;
            r_wait <= '0;
            if (len_i != '0) begin
              r_cyc   <= 1'b1;
              r_we    <= 1'b0;
              r_adr   <= src_i;
              r_state <= RD;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        RD: begin
          if (ack_i) begin
            r_dat   <= dat_i;
            r_we    <= 1'b1;
            r_adr   <= r_dst + ADR_W'(r_idx);
            r_wait  <= '0;
            r_state <= WR;
          end else if (w_timeout) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else if (TIMEOUT != 0) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        WR: begin
          if (ack_i) begin
            r_idx  <= w_idx_nx;
            r_wait <= '0;
            r_we   <= 1'b0;
            if (w_idx_nx == r_len) begin
              r_cyc   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_adr   <= r_src + ADR_W'(w_idx_nx);
              r_state <= RD;
            end
          end else if (w_timeout) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else if (TIMEOUT != 0) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master against a one-cycle-ack RAM model.
// ADR_W=8 for the wrap case, TIMEOUT=8 for the stall case.
module tb_wb_copy_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src = '0;
  logic [7:0]  dst = '0;
  logic [15:0] len = '0;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [3:0]  be_o;
  logic [7:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] rdata = '0;
  logic        ack = 1'b0;
  logic        stall = 1'b0;

  logic [31:0] mem [0:255];
  int          ack_total = 0;
  logic [7:0]  rd_log [0:1023];
  int          rd_total = 0;

  int errors = 0;
  int checks = 0;

  int dc;
  int first_stb;
  logic cyc_seen;
  logic busy_c1;
  int ack_base;
  int rd_base;
  int done_seen;

  wb_copy_master #(.ADR_W(8), .LEN_W(16), .TIMEOUT(8)) dut (
    .clk_i  (clk),
    .rst_in (rst_n),
    .start_i(start),
    .src_i  (src),
    .dst_i  (dst),
    .len_i  (len),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .we_o   (we_o),
    .be_o   (be_o),
    .adr_o  (adr_o),
    .dat_o  (dat_o),
    .dat_i  (rdata),
    .ack_i  (ack)
  );

  always #5 clk = ~clk;

  // RAM slave: acks one cycle after an un-acked strobe, so ack toggles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
    end else if (cyc_o && stb_o && !ack && !stall) begin
      if (we_o) mem[adr_o] <= dat_o;
      else begin
        rd_log[rd_total[9:0]] <= adr_o;
        rd_total <= rd_total + 1;
      end
      rdata <= mem[adr_o];
      ack <= 1'b1;
    end else begin
      ack <= 1'b0;
    end
  end

  always @(posedge clk) if (ack) ack_total <= ack_total + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start in cycle 0; returns done cycle (-1 on budget expiry).
  // inj>0 pulses a conflicting start in that cycle.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d,
                          input logic [15:0] l, input int inj);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    ack_base = ack_total;
    rd_base = rd_total;
    cyc_seen = 1'b0;
    first_stb = -1;
    busy_c1 = 1'b0;
    dc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == inj) begin
        start = 1'b1; src = 8'h20; dst = 8'h70; len = 16'd1;
      end
      if (n == 1) busy_c1 = busy_o;
      if (cyc_o) cyc_seen = 1'b1;
      if (stb_o && first_stb < 0) first_stb = n;
      if (done_o) begin
        dc = n;
        break;
      end
    end
    start = 1'b0;
    if (dc < 0) chk("done_budget", 32'(dc), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h11111111;
    mem[8'h11] = 32'h22222222;
    mem[8'h12] = 32'h33333333;
    mem[8'h13] = 32'h44444444;
    mem[8'hFE] = 32'hAAAA00FE;
    mem[8'hFF] = 32'hBBBB00FF;
    mem[8'h00] = 32'hCCCC0000;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_be", 32'(be_o), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Copy 4 words 0x10 -> 0x40
    run_copy(8'h10, 8'h40, 16'd4, 0);
    chk("c4_done_cyc", 32'(dc), 32'd17);
    chk("c4_err", 32'(err_o), 32'd0);
    chk("c4_first_stb", 32'(first_stb), 32'd1);
    chk("c4_busy_c1", 32'(busy_c1), 32'd1);
    chk("c4_busy_done", 32'(busy_o), 32'd1);
    chk("c4_cyc_done", 32'(cyc_o), 32'd0);
    @(negedge clk);
    chk("c4_acks", 32'(ack_total - ack_base), 32'd8);
    chk("c4_done_pulse", 32'(done_o), 32'd0);
    chk("c4_busy_after", 32'(busy_o), 32'd0);
    chk("c4_m40", mem[8'h40], 32'h11111111);
    chk("c4_m41", mem[8'h41], 32'h22222222);
    chk("c4_m42", mem[8'h42], 32'h33333333);
    chk("c4_m43", mem[8'h43], 32'h44444444);

    // Zero length
    run_copy(8'h10, 8'h50, 16'd0, 0);
    chk("z_done_cyc", 32'(dc), 32'd1);
    chk("z_cyc_seen", 32'(cyc_seen), 32'd0);
    chk("z_err", 32'(err_o), 32'd0);
    chk("z_m50", mem[8'h50], 32'h0);

    // Address wrap at 2^8
    run_copy(8'hFE, 8'h80, 16'd3, 0);
    chk("w_done_cyc", 32'(dc), 32'd13);
    @(negedge clk);
    chk("w_rd0", 32'(rd_log[rd_base[9:0]]), 32'hFE);
    chk("w_rd1", 32'(rd_log[rd_base[9:0] + 10'd1]), 32'hFF);
    chk("w_rd2", 32'(rd_log[rd_base[9:0] + 10'd2]), 32'h00);
    chk("w_m80", mem[8'h80], 32'hAAAA00FE);
    chk("w_m81", mem[8'h81], 32'hBBBB00FF);
    chk("w_m82", mem[8'h82], 32'hCCCC0000);

    // Stalled slave -> timeout
    stall = 1'b1;
    run_copy(8'h10, 8'hB0, 16'd2, 0);
    chk("to_done_cyc", 32'(dc), 32'd10);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_cyc", 32'(cyc_o), 32'd0);
    chk("to_stb", 32'(stb_o), 32'd0);
    @(negedge clk);
    chk("to_err_hold", 32'(err_o), 32'd1);
    chk("to_done_pulse", 32'(done_o), 32'd0);
    stall = 1'b0;
    run_copy(8'h10, 8'hB0, 16'd0, 0);
    chk("to_clr_done", 32'(dc), 32'd1);
    chk("to_clr_err", 32'(err_o), 32'd0);
    chk("to_mB0", mem[8'hB0], 32'h0);

    // Start pulsed mid-copy is ignored
    run_copy(8'h10, 8'h60, 16'd4, 5);
    chk("ms_done_cyc", 32'(dc), 32'd17);
    chk("ms_err", 32'(err_o), 32'd0);
    @(negedge clk);
    chk("ms_acks", 32'(ack_total - ack_base), 32'd8);
    chk("ms_m60", mem[8'h60], 32'h11111111);
    chk("ms_m63", mem[8'h63], 32'h44444444);
    chk("ms_m70", mem[8'h70], 32'h0);

    // Reset during the write of word 2
    @(negedge clk);
    src = 8'h10; dst = 8'h90; len = 16'd4; start = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rm_in_wr", 32'(we_o), 32'd1);
    chk("rm_adr_wr", 32'(adr_o), 32'h92);
    rst_n = 1'b0;
    #1;
    chk("rm_cyc", 32'(cyc_o), 32'd0);
    chk("rm_stb", 32'(stb_o), 32'd0);
    chk("rm_we", 32'(we_o), 32'd0);
    chk("rm_busy", 32'(busy_o), 32'd0);
    chk("rm_err", 32'(err_o), 32'd0);
    chk("rm_adr", 32'(adr_o), 32'd0);
    chk("rm_dat", dat_o, 32'd0);
    chk("rm_be", 32'(be_o), 32'hF);
    done_seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    chk("rm_no_done", 32'(done_seen), 32'd0);
    chk("rm_m90", mem[8'h90], 32'h11111111);
    chk("rm_m91", mem[8'h91], 32'h22222222);
    run_copy(8'h10, 8'hA0, 16'd4, 0);
    chk("rn_done_cyc", 32'(dc), 32'd17);
    chk("rn_err", 32'(err_o), 32'd0);
    @(negedge clk);
    chk("rn_mA0", mem[8'hA0], 32'h11111111);
    chk("rn_mA3", mem[8'hA3], 32'h44444444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_copy_master.md
# wb_copy_master

Wishbone classic initiator that copies a block of 32-bit words from one word address range to another on the SoC bus, one transfer at a time. It is the bus-driving counterpart of the single-port Wishbone RAM slaves. Typical uses are preloading RAM from ROM at boot and moving buffers without CPU involvement. Software or a boot FSM supplies source, destination and length, pulses start, and waits for done.

## Interface
- `ADR_W`, 30: word-address width of `adr_o`, `src_i`, `dst_i`.
- `LEN_W`, 16: width of the word count `len_i`.
- `TIMEOUT`, 1024: number of cycles to wait for `ack_i` before aborting. 0 disables the timeout.

- `clk_i`  in  1: clock. Everything is on the rising edge.
- `rst_in`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: start pulse. Sampled only in IDLE.
- `src_i`  in  ADR_W: source word address, captured at start.
- `dst_i`  in  ADR_W: destination word address, captured at start.
- `len_i`  in  LEN_W: number of words to copy, captured at start.
- `busy_o`  out  1: high from the cycle after start until `done_o`, inclusive.
- `done_o`  out  1: one-cycle completion pulse.
- `err_o`  out  1: qualifies `done_o`; high means the copy was aborted by timeout.
- `cyc_o`, `stb_o`  out  1: Wishbone cycle and strobe. Always driven together.
- `we_o`  out  1: write enable.
- `be_o`  out  4: byte enables. Constant 4'hF.
- `adr_o`  out  ADR_W: word address.
- `dat_o`  out  32: write data.
- `dat_i`  in  32: read data.
- `ack_i`  in  1: slave acknowledge.

## Operation
- All outputs are registered.
- Reset values: `cyc_o`, `stb_o`, `we_o`, `busy_o`, `done_o`, `err_o` = 0; `adr_o`, `dat_o` = 0; `be_o` = 4'hF. State resets to IDLE.
- States:
  - IDLE
    - `start_i` with `len_i`≠0: latch src, dst, len; clear the word index → RD.
    - `start_i` with `len_i`=0: → FIN with no bus activity.
  - RD: `cyc_o`=`stb_o`=1, `we_o`=0, `adr_o`=src+idx.
    - On `ack_i`: capture `dat_i` into `dat_o` → WR.
  - WR: `cyc_o`=`stb_o`=`we_o`=1, `adr_o`=dst+idx.
    - On `ack_i`: idx++. If idx+1==len → FIN, else → RD.
  - FIN: `cyc_o`=`stb_o`=0; `done_o`=1 for exactly one cycle → IDLE.
- Address arithmetic is modulo 2^ADR_W; it wraps silently. The index is LEN_W bits wide.
- The wait counter resets on every state entry and counts cycles spent in RD/WR without `ack_i`.
  - If `TIMEOUT`≠0 and the count reaches `TIMEOUT`: drop `cyc_o`/`stb_o`, go to FIN with `err_o`=1.
  - `err_o` holds until the next start is accepted.
- `start_i` while busy is ignored. `src_i`/`dst_i`/`len_i` changes after capture have no effect.
- `ack_i` outside RD/WR is ignored.
- Asserting `rst_in` mid-transfer aborts immediately: all outputs return to reset values and no `done_o` is issued. Memory already written stays written.

## Timing
- Let the cycle with `start_i`=1 in IDLE be cycle 0.
  - First `stb_o` is in cycle 1.
  - With a slave that acks one cycle after the strobe (the on-chip RAM), each access takes 2 cycles and each word 4 cycles.
  - `done_o` is high in cycle 4·len+1. For len=0, `done_o` is high in cycle 1.
- `cyc_o`/`stb_o` stay continuously high across the RD→WR and WR→RD transitions within a copy. The RAM slave's toggling ack tolerates this.
- The earliest next start is the cycle after `done_o`, when the block is back in IDLE.
- Timeout abort: `done_o` is high `TIMEOUT`+1 cycles after the unacknowledged strobe was first asserted.

## Structure
- Package `wb_copy_pkg` holds the state enum (IDLE, RD, WR, FIN). Shared Wishbone constants, e.g. the full byte-enable 4'hF, go there as well.
- The block is a single module with no sub-module. The wait counter is small enough to stay inline.

## Test plan
- Copy 4 words: preload the RAM model with 0x11111111..0x44444444 at words 0x10–0x13; src=0x10, dst=0x40, len=4. Required: words 0x40–0x43 match, `done_o` in cycle 17, `err_o`=0, exactly 8 acks.
- len=0: `done_o` in cycle 1, `cyc_o` never asserted.
- Wrap: ADR_W=8, src=0xFE, len=3. Reads hit addresses 0xFE, 0xFF, 0x00.
- Stalled slave: TIMEOUT=8 and `ack_i` held 0. `cyc_o` drops, `done_o`=1 with `err_o`=1 in cycle 10. A following start clears `err_o`.
- `start_i` pulsed mid-copy with different arguments: ignored, the original copy completes unchanged.
- `rst_in` asserted during a WR of word 2 of 4: outputs go to reset values asynchronously, no `done_o`. A new copy after reset completes correctly.
